// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
//   Iterative signed multiply / divide unit and its sequencer. It sits beside
//   the EX stage of the 16-bit 5-stage pipeline. While an op is in flight it
//   freezes the PC and the IF/ID and ID/EX buffers. It then hands {hi,lo} to
//   writeback: hi goes to R0 (product high / remainder) and lo goes to Rd
//   (product low / quotient).
//
//   Multiply uses shift-add on operand magnitudes, one bit per cycle, with a
//   2*WIDTH accumulator. Divide is restoring division on magnitudes, one
//   quotient bit per cycle. A FIX cycle then applies the two's-complement
//   signs. The quotient truncates toward zero, and the remainder takes the
//   dividend's sign.
//
// Parameters
//   WIDTH        operand/result width, also the iteration count
//
// Ports
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   start        request, sampled only in IDLE
//   op           01 signed MUL, 10 signed DIV, 00 none, 11 reserved/unsigned DIV
//   abort        synchronous cancel (pipeline flush), highest priority
//   operand_a    multiplicand / dividend
//   operand_b    multiplier / divisor
//   stall        combinational hold for PC, IF/ID, ID/EX
//   busy         registered, state != IDLE
//   done         one-cycle pulse, results valid
//   result_lo    product low half / quotient
//   result_hi    product high half / remainder
//   div_by_zero  set with done when a DIV had operand_b == 0
//
// Configuration
//   MULDIV_UNSIGNED_EN : when defined, op 11 is an unsigned DIV. It has the
//                        same latency and the same divide-by-zero rule. When
//                        undefined, op 11 is ignored like op 00.
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             abort,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;         // product / quotient sign
  logic               neg_rem_q, neg_rem_d; // remainder sign
  logic [WIDTH-1:0]   opnd_q, opnd_d;       // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   res_lo_q, res_lo_d;
  logic [WIDTH-1:0]   res_hi_q, res_hi_d;
  logic               dbz_q, dbz_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic op_mul, op_div, op_uns, op_valid, accept, b_zero;
  logic a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  always_comb begin
    op_mul = (op == 2'b01);
`ifdef MULDIV_UNSIGNED_EN
    op_uns = (op == 2'b11);
`else
    op_uns = 1'b0;
`endif
    op_div   = (op == 2'b10) | op_uns;
    op_valid = op_mul | op_div;
    // reset_n gating keeps stall low while reset is held, even if start is high
    accept   = reset_n & (state_q == ST_IDLE) & start & op_valid & ~abort;
    b_zero   = (operand_b == '0);
    a_neg    = ~op_uns & operand_a[WIDTH-1];
    b_neg    = ~op_uns & operand_b[WIDTH-1];
    mag_a    = a_neg ? (~operand_a + WIDTH'(1)) : operand_a;
    mag_b    = b_neg ? (~operand_b + WIDTH'(1)) : operand_b;
  end

  // ---------------------------------------------------------------------------
  // One iteration of each algorithm
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]     mul_sum, div_part, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next;

  always_comb begin
    // Shift-add: the low half holds the remaining multiplier bits. Add into
    // the high half with a carry, then shift the accumulator right by one.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
               (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring division: acc = {remainder, dividend/quotient}. The partial
    // remainder is shifted left with the next dividend bit, then the divisor
    // is trial-subtracted. A clear borrow bit means the subtraction is kept.
    div_part = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff = div_part - {1'b0, opnd_q};
    if (!div_diff[WIDTH])
      div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    else
      div_next = {div_part[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
  end

  // ---------------------------------------------------------------------------
  // Sign fix-up
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  always_comb begin
    prod_fix = neg_q     ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
    quot_fix = neg_q     ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + WIDTH'(1))
                         : acc_q[2*WIDTH-1:WIDTH];
  end

  // ---------------------------------------------------------------------------
  // Next state / outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    res_lo_d  = res_lo_q;
    res_hi_d  = res_hi_q;
    dbz_d     = dbz_q;
    stall     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          stall     = 1'b1;
          is_div_d  = op_div;
          cnt_d     = '0;
          dbz_d     = 1'b0;
          neg_d     = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          if (op_div) begin
            opnd_d = mag_b;
            acc_d  = {{WIDTH{1'b0}}, mag_a};
          end else begin
            opnd_d = mag_a;
            acc_d  = {{WIDTH{1'b0}}, mag_b};
          end
          if (op_div && b_zero) begin
            // Skip the iterations entirely and report the flagged result.
            state_d  = ST_DONE;
            res_lo_d = '1;
            res_hi_d = operand_a;
            dbz_d    = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        stall = 1'b1;
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = is_div_q ? div_next : mul_next;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_ITER) state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        stall = 1'b1;
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
          if (is_div_q) begin
            res_lo_d = quot_fix;
            res_hi_d = rem_fix;
          end else begin
            res_lo_d = prod_fix[WIDTH-1:0];
            res_hi_d = prod_fix[2*WIDTH-1:WIDTH];
          end
        end
      end
      ST_DONE: begin
        // The done pulse always completes, even if abort is asserted here.
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      opnd_q    <= '0;
      acc_q     <= '0;
      res_lo_q  <= '0;
      res_hi_q  <= '0;
      dbz_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      res_lo_q  <= res_lo_d;
      res_hi_q  <= res_hi_d;
      dbz_q     <= dbz_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result_lo   = res_lo_q;
  assign result_hi   = res_hi_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
//   Directed, table-driven bench for muldiv_sequencer (WIDTH = 16). A vector
//   table covers MUL and DIV results, including the sign and edge cases.
//   Hand-written sequences cover abort, start with abort, start while busy,
//   reset mid-operation, and op 11.
//   Latency is counted in edges after the accepting edge. That is 17 for a
//   normal op and 0 for a divide by zero, where done follows the accept edge.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic        abort;
  logic [15:0] operand_a, operand_b;
  logic        stall, busy, done, div_by_zero;
  logic [15:0] result_lo, result_hi;

  int n_chk  = 0;
  int n_fail = 0;

  muldiv_sequencer #(.WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .abort(abort),
    .operand_a(operand_a), .operand_b(operand_b),
    .stall(stall), .busy(busy), .done(done),
    .result_lo(result_lo), .result_hi(result_hi), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a, b, lo, hi;
    logic        dbz;
    int          lat;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at #1 after a posedge with the unit idle. Presents the request,
  // checks that stall is high in the issuing cycle, and then returns at #1
  // after the accepting edge.
  task automatic issue(input string tag, input logic [1:0] o, input logic [15:0] a,
                       input logic [15:0] b);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    #1 chk({tag, " stall@issue"}, 32'(stall), 32'd1);
    @(posedge clk); #1;
    start = 1'b0; op = 2'b00;
  endtask

  // Entered at #1 after some edge. Waits for done and counts the edges
  // crossed and the stall-high samples seen before done rises.
  task automatic wait_done(output int lat, output int stall_cnt);
    lat = -1; stall_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin lat = i; break; end
      if (stall) stall_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic run_vec(input int idx);
    int lat, sc;
    string t;
    t = $sformatf("vec%0d", idx);
    issue(t, vecs[idx].op, vecs[idx].a, vecs[idx].b);
    wait_done(lat, sc);
    chk({t, " latency"}, 32'(lat), 32'(vecs[idx].lat));
    chk({t, " stall_cycles"}, 32'(sc), 32'(vecs[idx].lat));
    chk({t, " stall@done"}, 32'(stall), 32'd0);
    chk({t, " lo"}, 32'(result_lo), 32'(vecs[idx].lo));
    chk({t, " hi"}, 32'(result_hi), 32'(vecs[idx].hi));
    chk({t, " dbz"}, 32'(div_by_zero), 32'(vecs[idx].dbz));
    @(posedge clk); #1;
    chk({t, " done_pulse_end"}, 32'(done), 32'd0);
    chk({t, " busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int lat, sc, seen;

    vecs[0]  = '{op:2'b01, a:16'h0003, b:16'hFFFB, lo:16'hFFF1, hi:16'hFFFF, dbz:1'b0, lat:17};
    vecs[1]  = '{op:2'b10, a:16'hFFF9, b:16'h0002, lo:16'hFFFD, hi:16'hFFFF, dbz:1'b0, lat:17};
    vecs[2]  = '{op:2'b10, a:16'h1234, b:16'h0000, lo:16'hFFFF, hi:16'h1234, dbz:1'b1, lat:0};
    vecs[3]  = '{op:2'b10, a:16'h8000, b:16'hFFFF, lo:16'h8000, hi:16'h0000, dbz:1'b0, lat:17};
    vecs[4]  = '{op:2'b01, a:16'h7FFF, b:16'h7FFF, lo:16'h0001, hi:16'h3FFF, dbz:1'b0, lat:17};
    vecs[5]  = '{op:2'b01, a:16'h8000, b:16'h8000, lo:16'h0000, hi:16'h4000, dbz:1'b0, lat:17};
    vecs[6]  = '{op:2'b01, a:16'hFFFF, b:16'hFFFF, lo:16'h0001, hi:16'h0000, dbz:1'b0, lat:17};
    vecs[7]  = '{op:2'b10, a:16'h0064, b:16'h0007, lo:16'h000E, hi:16'h0002, dbz:1'b0, lat:17};
    vecs[8]  = '{op:2'b10, a:16'h0007, b:16'hFFFE, lo:16'hFFFD, hi:16'h0001, dbz:1'b0, lat:17};
    vecs[9]  = '{op:2'b10, a:16'hFFF9, b:16'hFFFE, lo:16'h0003, hi:16'hFFFF, dbz:1'b0, lat:17};
    vecs[10] = '{op:2'b01, a:16'h1234, b:16'hFFFF, lo:16'hEDCC, hi:16'hFFFF, dbz:1'b0, lat:17};

    reset_n = 1'b0; start = 1'b0; op = 2'b00; abort = 1'b0;
    operand_a = '0; operand_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", {26'd0, stall, busy, done, div_by_zero, |result_lo, |result_hi}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) run_vec(i);

    // abort in the 5th RUN cycle of a MUL: back to IDLE, no done, old results kept
    issue("abort", 2'b01, 16'h0002, 16'h0003);
    repeat (4) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort stall", 32'(stall), 32'd0);
    chk("abort lo held", 32'(result_lo), 32'h0000EDCC);
    chk("abort hi held", 32'(result_hi), 32'h0000FFFF);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) seen = 1;
      @(posedge clk); #1;
    end
    chk("abort no done", 32'(seen), 32'd0);

    // start together with abort in IDLE: not accepted
    start = 1'b1; op = 2'b01; abort = 1'b1; operand_a = 16'h0005; operand_b = 16'h0005;
    #1 chk("start+abort stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0; op = 2'b00;
    chk("start+abort busy", 32'(busy), 32'd0);

    // start pulsed while busy: ignored, and no second op runs afterwards
    issue("busy", 2'b01, 16'h0003, 16'h0004);
    start = 1'b1; op = 2'b10; operand_a = 16'h0064; operand_b = 16'h0007;
    repeat (3) @(posedge clk);
    #1 start = 1'b0; op = 2'b00;
    wait_done(lat, sc);
    chk("busy latency", 32'(lat + 3), 32'd17);
    chk("busy lo", 32'(result_lo), 32'h0000000C);
    chk("busy hi", 32'(result_hi), 32'h00000000);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (busy) seen = 1;
    end
    chk("busy no requeue", 32'(seen), 32'd0);

    // reset_n low in RUN: all outputs clear at once
    issue("rst", 2'b01, 16'h0005, 16'h0005);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b0;
    #1 chk("reset in RUN", {26'd0, stall, busy, done, div_by_zero, |result_lo, |result_hi}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

`ifdef MULDIV_UNSIGNED_EN
    issue("udiv", 2'b11, 16'hFFFF, 16'h0010);
    wait_done(lat, sc);
    chk("udiv latency", 32'(lat), 32'd17);
    chk("udiv lo", 32'(result_lo), 32'h00000FFF);
    chk("udiv hi", 32'(result_hi), 32'h0000000F);
    chk("udiv dbz", 32'(div_by_zero), 32'd0);
    @(posedge clk); #1;
`else
    start = 1'b1; op = 2'b11; operand_a = 16'hFFFF; operand_b = 16'h0010;
    #1 chk("op11 stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    start = 1'b0; op = 2'b00;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (done || busy) seen = 1;
      @(posedge clk); #1;
    end
    chk("op11 ignored", 32'(seen), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
